fsm_ksa: RTL and testbench

// RC4 key-scheduling (KSA swap) controller; runs after the S-array init pass has written S[i]=i.

---
 rtl/fsm_ksa_if.sv | 15 +
 rtl/fsm_ksa.sv | 149 ++++++++++++++
 tb/tb_fsm_ksa.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_ksa_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fsm_ksa_if : single-port 256x8 S RAM port (address/write data/wren/q)    |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
interface fsm_ksa_if;
  logic [7:0] Address;
  logic [7:0] data;
  logic       wren;
  logic [7:0] q;

  modport master (output Address, output data, output wren, input q);
  modport slave  (input Address, input data, input wren, output q);
endinterface
`default_nettype wire

// File: rtl/fsm_ksa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fsm_ksa  : RC4 key-scheduling swap controller over a shared S RAM port   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fsm_ksa #(
  parameter int KEY_BYTES = 3,
  parameter int RD_WAIT   = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   rst,
  input  logic                   In_Start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  fsm_ksa_if.master              ram,
  output logic                   KSA_Finish
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [KW-1:0] KEY_LAST  = KW'(KEY_BYTES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((RD_WAIT > 0) ? RD_WAIT - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RD_SI    = 4'd1,
    S_WAIT_SI  = 4'd2,
    S_LATCH_SI = 4'd3,
    S_RD_SJ    = 4'd4,
    S_WAIT_SJ  = 4'd5,
    S_LATCH_SJ = 4'd6,
    S_WR_SI    = 4'd7,
    S_WR_SJ    = 4'd8,
    S_INC_I    = 4'd9,
    S_DONE     = 4'd10
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_i;
  logic [7:0]      r_j;
  logic [7:0]      r_si;
  logic [7:0]      r_sj;
  logic [KW-1:0]   r_kidx;
  logic [WW-1:0]   r_wait;
  logic            r_finish;
  logic [7:0]      w_key;

  // Key byte 0 sits in the most significant byte of secret_key.
  always_comb begin
    w_key = 8'd0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (r_kidx == KW'(k)) w_key = secret_key[8*(KEY_BYTES-1-k) +: 8];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    ram.Address = 8'd0;
    ram.data    = 8'd0;
    ram.wren    = 1'b0;
    case (r_state)
      S_IDLE:     if (In_Start) w_next = S_RD_SI;
      S_RD_SI: begin
        ram.Address = r_i;
        w_next      = (RD_WAIT == 0) ? S_LATCH_SI : S_WAIT_SI;
      end
      S_WAIT_SI: begin
        ram.Address = r_i;
        if (r_wait == WAIT_LAST) w_next = S_LATCH_SI;
      end
      S_LATCH_SI: begin
        ram.Address = r_i;
        w_next      = S_RD_SJ;
      end
      S_RD_SJ: begin
        ram.Address = r_j;
        w_next      = (RD_WAIT == 0) ? S_LATCH_SJ : S_WAIT_SJ;
      end
      S_WAIT_SJ: begin
        ram.Address = r_j;
        if (r_wait == WAIT_LAST) w_next = S_LATCH_SJ;
      end
      S_LATCH_SJ: begin
        ram.Address = r_j;
        w_next      = S_WR_SI;
      end
      S_WR_SI: begin
        ram.Address = r_i;
        ram.data    = r_sj;
        ram.wren    = 1'b1;
        w_next      = S_WR_SJ;
      end
      S_WR_SJ: begin
        ram.Address = r_j;
        ram.data    = r_si;
        ram.wren    = 1'b1;
        w_next      = S_INC_I;
      end
      S_INC_I:    w_next = (r_i == 8'hFF) ? S_DONE : S_RD_SI;
      S_DONE:     w_next = S_DONE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      r_i      <= 8'd0;
      r_j      <= 8'd0;
      r_si     <= 8'd0;
      r_sj     <= 8'd0;
      r_kidx   <= '0;
      r_wait   <= '0;
      r_finish <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (In_Start) begin
            r_i    <= 8'd0;
            r_j    <= 8'd0;
            r_kidx <= '0;
          end
        end
        S_WAIT_SI, S_WAIT_SJ: r_wait <= (r_wait == WAIT_LAST) ? '0 : r_wait + WW'(1);
        S_LATCH_SI: begin
          r_si <= ram.q;
          r_j  <= r_j + ram.q + w_key;
        end
        S_LATCH_SJ: r_sj <= ram.q;
        S_INC_I: begin
          if (r_i != 8'hFF) begin
            r_i    <= r_i + 8'd1;
            r_kidx <= (r_kidx == KEY_LAST) ? '0 : r_kidx + KW'(1);
          end
        end
        S_DONE:  r_finish <= 1'b1;
        default: ;
      endcase
    end
  end

  assign KSA_Finish = r_finish;

endmodule
`default_nettype wire

// File: tb/tb_fsm_ksa.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fsm_ksa : bench for fsm_ksa against a software RC4 KSA model          |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module tb_fsm_ksa;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        In_Start = 1'b0;
  logic [23:0] key = 24'd0;
  logic        KSA_Finish;

  fsm_ksa_if ram ();

  fsm_ksa #(.KEY_BYTES(3), .RD_WAIT(1)) dut (
    .CLOCK_50   (clk),
    .rst        (rst),
    .In_Start   (In_Start),
    .secret_key (key),
    .ram        (ram),
    .KSA_Finish (KSA_Finish)
  );

  always #10 clk = ~clk;

  // RAM with registered read address plus a log of every write cycle.
  logic [7:0]  mem [256];
  logic [7:0]  addr_q = 8'd0;
  logic        mem_init = 1'b0;
  logic        log_clr = 1'b0;
  logic [15:0] wr_q [$];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (ram.wren) begin
      mem[ram.Address] <= ram.data;
    end
    addr_q <= ram.Address;
    if (log_clr) wr_q.delete();
    else if (ram.wren) wr_q.push_back({ram.Address, ram.data});
  end
  assign ram.q = mem[addr_q];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  exp_s [256];
  logic [15:0] exp_w [$];

  task automatic model_ksa(input logic [23:0] k);
    int j;
    logic [7:0] t, kb;
    exp_w.delete();
    for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(k >> (8 * (2 - (i % 3))));
      j = (j + int'(exp_s[i]) + int'(kb)) % 256;
      exp_w.push_back({8'(i), exp_s[j]});
      exp_w.push_back({8'(j), exp_s[i]});
      t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; In_Start = 1'b0; mem_init = 1'b1; log_clr = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0; log_clr = 1'b0; rst = 1'b0;
  endtask

  // Returns the number of rising edges from the one sampling In_Start until KSA_Finish is seen.
  task automatic run_ksa(input bit toggle, output int cyc);
    @(negedge clk); In_Start = 1'b1;
    @(posedge clk); #1; In_Start = 1'b0;
    cyc = 0;
    while (KSA_Finish !== 1'b1 && cyc < 5000) begin
      @(posedge clk); #1; cyc++;
      if (toggle) In_Start = 1'($urandom % 2);
    end
    In_Start = 1'b0;
    n_checks++;
    if (KSA_Finish !== 1'b1) begin
      n_fail++; $display("FAIL run_timeout: KSA_Finish=%b after %0d cycles, required 1", KSA_Finish, cyc);
    end
  endtask

  task automatic test_reset();
    int cyc, n;
    bit seen;
    do_reset(); #1;
    n_checks++; if (ram.Address !== 8'd0) begin n_fail++; $display("FAIL reset_addr: got %h want 00", ram.Address); end
    n_checks++; if (ram.data !== 8'd0) begin n_fail++; $display("FAIL reset_data: got %h want 00", ram.data); end
    n_checks++; if (ram.wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", ram.wren); end
    n_checks++; if (KSA_Finish !== 1'b0) begin n_fail++; $display("FAIL reset_finish: got %b want 0", KSA_Finish); end
    key = 24'h010203;
    @(negedge clk); In_Start = 1'b1;
    @(posedge clk); #1; In_Start = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1; n++;
      seen = (ram.wren === 1'b1);
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL reset_first_write: no wren within %0d cycles, required one", n); end
    @(negedge clk); rst = 1'b1; #1;
    n_checks++; if (ram.wren !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_wren: got %b want 0", ram.wren); end
    n_checks++; if (ram.Address !== 8'd0) begin n_fail++; $display("FAIL midrun_rst_addr: got %h want 00", ram.Address); end
    n_checks++; if (KSA_Finish !== 1'b0) begin n_fail++; $display("FAIL midrun_rst_finish: got %b want 0", KSA_Finish); end
    @(negedge clk); rst = 1'b0;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (ram.wren !== 1'b0 || ram.Address !== 8'd0) n++;
    end
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL idle_after_rst: %0d active cycles, required 0", n); end
    do_reset();
    model_ksa(key);
    run_ksa(1'b0, cyc);
    n = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) n++;
    n_checks++; if (n != 0) begin n_fail++; $display("FAIL restart_array: %0d bytes differ, required 0", n); end
  endtask

  task automatic test_first_writes();
    int cyc;
    logic [15:0] want [4];
    want = '{16'h0001, 16'h0100, 16'h0103, 16'h0300};
    do_reset();
    key = 24'h010203;
    run_ksa(1'b0, cyc);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wr_q.size() <= k || wr_q[k] !== want[k]) begin
        n_fail++; $display("FAIL first_write_%0d: got %h want %h", k, (wr_q.size() > k) ? wr_q[k] : 16'hxxxx, want[k]);
      end
    end
  endtask

  task automatic test_timing();
    int cyc;
    do_reset();
    key = 24'($urandom);
    run_ksa(1'b0, cyc);
    n_checks++; if (cyc != 2305) begin n_fail++; $display("FAIL finish_latency: got %0d cycles want 2305", cyc); end
    n_checks++; if (wr_q.size() != 512) begin n_fail++; $display("FAIL write_count: got %0d want 512", wr_q.size()); end
  endtask

  task automatic test_key_zero();
    int cyc;
    do_reset();
    key = 24'h000000;
    run_ksa(1'b0, cyc);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (wr_q.size() <= k || wr_q[k] !== 16'h0000) begin
        n_fail++; $display("FAIL zero_key_write_%0d: got %h want 0000", k, (wr_q.size() > k) ? wr_q[k] : 16'hxxxx);
      end
    end
  endtask

  task automatic test_keys();
    logic [23:0] keys [5];
    int cyc, dup, nw;
    bit seen [256];
    keys = '{24'h000000, 24'h000249, 24'hFFFFFF, 24'h0, 24'h0};
    keys[3] = 24'($urandom);
    keys[4] = 24'($urandom);
    for (int t = 0; t < 5; t++) begin
      do_reset();
      key = keys[t];
      model_ksa(key);
      run_ksa(t >= 3, cyc);
      for (int k = 0; k < 256; k++) begin
        n_checks++;
        if (mem[k] !== exp_s[k]) begin
          n_fail++; $display("FAIL final_s key=%h S[%0d]: got %h want %h", key, k, mem[k], exp_s[k]);
        end
      end
      dup = 0;
      for (int k = 0; k < 256; k++) seen[k] = 1'b0;
      for (int k = 0; k < 256; k++) begin
        if (seen[mem[k]]) dup++;
        seen[mem[k]] = 1'b1;
      end
      n_checks++; if (dup != 0) begin n_fail++; $display("FAIL permutation key=%h: %0d duplicates, required 0", key, dup); end
      nw = 0;
      for (int k = 0; k < 512; k++) if (wr_q.size() <= k || wr_q[k] !== exp_w[k]) nw++;
      n_checks++; if (nw != 0 || wr_q.size() != 512) begin
        n_fail++; $display("FAIL write_seq key=%h: %0d writes differ, size %0d want 512", key, nw, wr_q.size());
      end
    end
  endtask

  task automatic test_done_hold();
    logic [7:0] a;
    int nbad;
    #1;
    a = ram.Address;
    nbad = 0;
    @(negedge clk); In_Start = 1'b1;
    @(negedge clk); In_Start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (c == 50) In_Start = 1'b1;
      if (c == 51) In_Start = 1'b0;
      n_checks++;
      if (ram.wren !== 1'b0 || ram.Address !== a || KSA_Finish !== 1'b1) begin
        n_fail++; nbad++;
        if (nbad < 5) $display("FAIL done_hold c=%0d: wren=%b addr=%h fin=%b, want 0 %h 1", c, ram.wren, ram.Address, KSA_Finish, a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_writes();
    test_timing();
    test_key_zero();
    test_keys();
    test_done_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
